// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial-to-parallel word assembler with downstream queue handshake
//
// Optional feature macro: DESERIALIZER_PARITY_EN
//   undefined : 8-bit words, parity_err_out tied low
//   defined   : 8 data bits followed by one even-parity bit; bad words are dropped
//
// Word flow: RECV collects bits MSB-first, HOLD waits for queue space,
// PUSH emits a single enqueue strobe, ACK_WAIT holds data_ready_out until ack.
// All outputs are registered and updated together with the state.

module deserializer (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic       write_in,
  input  logic       ack_in,
  input  logic [7:0] queue_len_in,
  output logic       status_out,
  output logic [7:0] data_out,
  output logic       enq_out,
  output logic       data_ready_out,
  output logic       parity_err_out
);

  typedef enum logic [1:0] {
    RECV     = 2'd0,
    HOLD     = 2'd1,
    PUSH     = 2'd2,
    ACK_WAIT = 2'd3
  } state_t;

  // Index of the final serial bit of a word (counter value when it arrives).
`ifdef DESERIALIZER_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  // Downstream queue depth; occupancy at or above this means full.
  localparam logic [7:0] QUEUE_DEPTH = 8'd8;

  state_t     state;
  logic [7:0] shift_reg;
  logic [3:0] bit_count;
  logic [7:0] shift_next;
  logic       queue_has_room;
  logic       last_bit;

  // Next shift-register value: new bit enters at the LSB so the first bit ends in bit 7.
  assign shift_next     = {shift_reg[6:0], data_in};
  assign queue_has_room = (queue_len_in < QUEUE_DEPTH);
  assign last_bit       = (bit_count == LAST_BIT);

  // Single state machine owning all state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= RECV;
      shift_reg      <= 8'h00;
      bit_count      <= 4'd0;
      data_out       <= 8'h00;
      status_out     <= 1'b1;
      enq_out        <= 1'b0;
      data_ready_out <= 1'b0;
      parity_err_out <= 1'b0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      enq_out        <= 1'b0;
      parity_err_out <= 1'b0;

      case (state)
        RECV: begin
          // Idle cycles (write_in low) leave everything untouched; no timeout.
          if (write_in) begin
            if (last_bit) begin
`ifdef DESERIALIZER_PARITY_EN
              // Final bit is even parity over the 8 data bits already shifted in.
              if ((^shift_reg ^ data_in) == 1'b0) begin
                data_out   <= shift_reg;
                bit_count  <= bit_count + 4'd1;
                state      <= HOLD;
                status_out <= 1'b0;
              end else begin
                // Bad word: drop it and start over, keeping the last good data_out.
                parity_err_out <= 1'b1;
                shift_reg      <= 8'h00;
                bit_count      <= 4'd0;
              end
`else
              shift_reg  <= shift_next;
              data_out   <= shift_next;
              bit_count  <= bit_count + 4'd1;
              state      <= HOLD;
              status_out <= 1'b0;
`endif
            end else begin
              shift_reg <= shift_next;
              bit_count <= bit_count + 4'd1;
            end
          end
        end

        HOLD: begin
          // Serial bits are dropped here; wait for the downstream queue to have room.
          if (queue_has_room) begin
            state   <= PUSH;
            enq_out <= 1'b1;
          end
        end

        PUSH: begin
          // Enqueue strobe lasts this one cycle; ack here is too early and ignored.
          state          <= ACK_WAIT;
          data_ready_out <= 1'b1;
        end

        ACK_WAIT: begin
          // data_out is retained after ack; only the next completed word replaces it.
          if (ack_in) begin
            state          <= RECV;
            data_ready_out <= 1'b0;
            status_out     <= 1'b1;
            bit_count      <= 4'd0;
            shift_reg      <= 8'h00;
          end
        end

        default: begin
          state          <= RECV;
          status_out     <= 1'b1;
          data_ready_out <= 1'b0;
          bit_count      <= 4'd0;
          shift_reg      <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed self-checking bench for deserializer

module tb_deserializer;

  logic       clock = 1'b0;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       ack_in;
  logic [7:0] queue_len_in;
  logic       status_out;
  logic [7:0] data_out;
  logic       enq_out;
  logic       data_ready_out;
  logic       parity_err_out;

  int checks     = 0;
  int failures   = 0;
  int enq_count  = 0;
  int perr_count = 0;

  deserializer dut (
    .clock          (clock),
    .reset          (reset),
    .data_in        (data_in),
    .write_in       (write_in),
    .ack_in         (ack_in),
    .queue_len_in   (queue_len_in),
    .status_out     (status_out),
    .data_out       (data_out),
    .enq_out        (enq_out),
    .data_ready_out (data_ready_out),
    .parity_err_out (parity_err_out)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (enq_out) enq_count = enq_count + 1;
    if (parity_err_out) perr_count = perr_count + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic ack_word;
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
  endtask

  // Sends w MSB-first with gap idle cycles between bits; appends parity when enabled.
  task automatic send_word(input logic [7:0] w, input int gap, input logic flip);
    logic [8:0] bits;
    int n;
`ifdef DESERIALIZER_PARITY_EN
    bits = {w, (^w) ^ flip};
    n = 9;
`else
    bits = {w, 1'b0};
    n = 8;
    if (flip) bits[0] = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) tick();
      data_in  = bits[8 - i];
      write_in = 1'b1;
      tick();
      write_in = 1'b0;
    end
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 40 && !data_ready_out; i++) tick();
    checks++;
    if (data_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout data_ready_out=%b required 1", name, data_ready_out);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0; queue_len_in = 8'd0;
    tick(); tick();
    reset = 1'b0;
    // partial word, then reset together with write_in and ack_in
    for (int i = 0; i < 3; i++) begin
      data_in = 1'b1; write_in = 1'b1; tick();
    end
    reset = 1'b1; ack_in = 1'b1;
    tick();
    reset = 1'b0; write_in = 1'b0; ack_in = 1'b0; data_in = 1'b0;
    checks++;
    if ({status_out, data_out, enq_out, data_ready_out, parity_err_out} !== {1'b1, 8'h00, 3'b000}) begin
      failures++;
      $display("FAIL reset_state got st=%b d=%h e=%b r=%b p=%b required st=1 d=00 e=0 r=0 p=0",
               status_out, data_out, enq_out, data_ready_out, parity_err_out);
    end
  endtask

  task automatic test_basic;
    int base;
    base = enq_count;
    queue_len_in = 8'd0;
    send_word(8'hA5, 0, 1'b0);
    checks++;
    if ({status_out, enq_out, data_out} !== {2'b00, 8'hA5}) begin
      failures++;
      $display("FAIL basic_hold got st=%b e=%b d=%h required st=0 e=0 d=a5", status_out, enq_out, data_out);
    end
    tick();
    checks++;
    if (enq_out !== 1'b1) begin
      failures++;
      $display("FAIL basic_enq_latency enq_out=%b required 1", enq_out);
    end
    tick();
    checks++;
    if ({enq_out, data_ready_out} !== 2'b01) begin
      failures++;
      $display("FAIL basic_ack_wait got e=%b r=%b required e=0 r=1", enq_out, data_ready_out);
    end
    tick(); tick();
    checks++;
    if (data_ready_out !== 1'b1 || (enq_count - base) != 1) begin
      failures++;
      $display("FAIL basic_ready_held got r=%b enq=%0d required r=1 enq=1", data_ready_out, enq_count - base);
    end
    ack_word();
    checks++;
    if ({status_out, data_ready_out, data_out} !== {2'b10, 8'hA5}) begin
      failures++;
      $display("FAIL basic_after_ack got st=%b r=%b d=%h required st=1 r=0 d=a5", status_out, data_ready_out, data_out);
    end
  endtask

  task automatic test_backpressure;
    int base;
    base = enq_count;
    queue_len_in = 8'd8;
    send_word(8'h5A, 0, 1'b0);
    repeat (5) tick();
    checks++;
    if ((enq_count - base) != 0 || status_out !== 1'b0 || data_ready_out !== 1'b0) begin
      failures++;
      $display("FAIL bp_full got enq=%0d st=%b r=%b required enq=0 st=0 r=0", enq_count - base, status_out, data_ready_out);
    end
    queue_len_in = 8'd7;
    tick();
    checks++;
    if (enq_out !== 1'b1) begin
      failures++;
      $display("FAIL bp_release enq_out=%b required 1", enq_out);
    end
    tick();
    checks++;
    if (data_ready_out !== 1'b1 || (enq_count - base) != 1 || data_out !== 8'h5A) begin
      failures++;
      $display("FAIL bp_single got r=%b enq=%0d d=%h required r=1 enq=1 d=5a", data_ready_out, enq_count - base, data_out);
    end
    ack_word();
    queue_len_in = 8'd0;
  endtask

  task automatic test_gaps;
    int base;
    base = enq_count;
    send_word(8'h3C, 3, 1'b0);
    wait_ready("gaps");
    checks++;
    if (data_out !== 8'h3C || (enq_count - base) != 1) begin
      failures++;
      $display("FAIL gaps_word got d=%h enq=%0d required d=3c enq=1", data_out, enq_count - base);
    end
    ack_word();
  endtask

  task automatic test_ignored;
    int base;
    base = enq_count;
    queue_len_in = 8'd8;
    send_word(8'h33, 0, 1'b0);
    data_in = 1'b1; write_in = 1'b1;
    repeat (3) tick();
    checks++;
    if (status_out !== 1'b0 || data_out !== 8'h33) begin
      failures++;
      $display("FAIL ign_hold got st=%b d=%h required st=0 d=33", status_out, data_out);
    end
    queue_len_in = 8'd0; ack_in = 1'b1;
    tick();
    checks++;
    if (enq_out !== 1'b1) begin
      failures++;
      $display("FAIL ign_push enq_out=%b required 1", enq_out);
    end
    tick();
    ack_in = 1'b0;
    checks++;
    if ({data_ready_out, status_out} !== 2'b10) begin
      failures++;
      $display("FAIL ign_ack_in_push got r=%b st=%b required r=1 st=0", data_ready_out, status_out);
    end
    tick();
    checks++;
    if (data_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL ign_ack_wait_held data_ready_out=%b required 1", data_ready_out);
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0; write_in = 1'b0; data_in = 1'b0;
    send_word(8'h0F, 0, 1'b0);
    wait_ready("ign");
    checks++;
    if (data_out !== 8'h0F || (enq_count - base) != 2) begin
      failures++;
      $display("FAIL ign_next_word got d=%h enq=%0d required d=0f enq=2", data_out, enq_count - base);
    end
    ack_word();
  endtask

  task automatic test_reset_midword;
    int base;
    base = enq_count;
    for (int i = 0; i < 5; i++) begin
      data_in = i[0]; write_in = 1'b1; tick();
    end
    write_in = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (status_out !== 1'b1 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid got st=%b d=%h required st=1 d=00", status_out, data_out);
    end
    send_word(8'hFF, 0, 1'b0);
    wait_ready("rst_mid");
    checks++;
    if (data_out !== 8'hFF || (enq_count - base) != 1) begin
      failures++;
      $display("FAIL rst_mid_word got d=%h enq=%0d required d=ff enq=1", data_out, enq_count - base);
    end
    ack_word();
    // reset while a word is held behind a full queue
    queue_len_in = 8'd8;
    send_word(8'h12, 0, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    queue_len_in = 8'd0;
    repeat (4) tick();
    checks++;
    if ((enq_count - base) != 1 || data_out !== 8'h00 || data_ready_out !== 1'b0 || status_out !== 1'b1) begin
      failures++;
      $display("FAIL rst_hold got enq=%0d d=%h r=%b st=%b required enq=1 d=00 r=0 st=1",
               enq_count - base, data_out, data_ready_out, status_out);
    end
  endtask

  task automatic test_parity;
`ifdef DESERIALIZER_PARITY_EN
    int base_e;
    int base_p;
    base_e = enq_count;
    base_p = perr_count;
    send_word(8'h81, 0, 1'b1);
    checks++;
    if ({parity_err_out, status_out, enq_out, data_out} !== {3'b110, 8'h00}) begin
      failures++;
      $display("FAIL par_bad got p=%b st=%b e=%b d=%h required p=1 st=1 e=0 d=00",
               parity_err_out, status_out, enq_out, data_out);
    end
    tick();
    checks++;
    if (parity_err_out !== 1'b0) begin
      failures++;
      $display("FAIL par_pulse parity_err_out=%b required 0", parity_err_out);
    end
    tick();
    checks++;
    if ((enq_count - base_e) != 0 || (perr_count - base_p) != 1) begin
      failures++;
      $display("FAIL par_bad_counts got enq=%0d perr=%0d required enq=0 perr=1", enq_count - base_e, perr_count - base_p);
    end
    send_word(8'h81, 0, 1'b0);
    checks++;
    if (data_out !== 8'h81 || status_out !== 1'b0) begin
      failures++;
      $display("FAIL par_good got d=%h st=%b required d=81 st=0", data_out, status_out);
    end
    tick();
    checks++;
    if (enq_out !== 1'b1) begin
      failures++;
      $display("FAIL par_good_enq enq_out=%b required 1", enq_out);
    end
    tick();
    ack_word();
`else
    checks++;
    if (perr_count != 0 || parity_err_out !== 1'b0) begin
      failures++;
      $display("FAIL par_tied got perr=%0d p=%b required perr=0 p=0", perr_count, parity_err_out);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_ignored();
    test_reset_midword();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
